// File: rtl/mole_sel_gen_pkg.sv
// rtl/mole_sel_gen_pkg.sv - state encodings, LFSR taps and score width for the mole sequencer
package mole_sel_gen_pkg;

  // Sequencer states (2-bit, legacy-compatible encoding)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1 expressed as a mask over q[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int SCORE_W = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;
  localparam logic [SCORE_W-1:0] SCORE_ONE = 8'd1;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // An all-zero state would lock the LFSR, so a zero seed is promoted to 1
  function automatic logic [7:0] lfsr_fix_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/mole_lfsr8.sv
// rtl/mole_lfsr8.sv - free-running 8-bit Fibonacci LFSR used to pick the next hole
module mole_lfsr8
  import mole_sel_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;

  // Advance every clock regardless of game state; reset reloads the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= lfsr_fix_seed(seed);
    end else begin
      q_q <= lfsr_step(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mole_sel_gen.sv
// rtl/mole_sel_gen.sv - whack-a-mole round sequencer driving the 4:1 hole mux; optional MOLE_SPEEDUP_EN
module mole_sel_gen
  import mole_sel_gen_pkg::*;
#(
  parameter int               TMR_W      = 24,
  parameter logic [TMR_W-1:0] UP_CYCLES  = 24'd5000000,
  parameter logic [TMR_W-1:0] GAP_CYCLES = 24'd1000000,
  parameter logic [TMR_W-1:0] MIN_UP     = 24'd1000000,
  parameter logic [7:0]       ROUNDS     = 8'd30,
  parameter logic [7:0]       LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hit,
  output logic               se1,
  output logic               se2,
  output logic               mole_up,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  logic [1:0]         state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]         round_q, round_d;
  logic [7:0]         round_inc;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         sel_q, sel_d;
  logic               mole_up_q, mole_up_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               miss_pulse_q, miss_pulse_d;
  logic               game_over_q, game_over_d;
  logic               hit_q, rise_q;
  logic [7:0]         lfsr_q;
  logic [TMR_W-1:0]   up_len;

  mole_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign round_inc = round_q + 8'd1;

`ifdef MOLE_SPEEDUP_EN
  logic [TMR_W-1:0] up_len_q, up_len_d, up_len_shrunk;
  logic             unused_lfsr;

  assign up_len_shrunk = up_len_q - (up_len_q >> 3);
  assign unused_lfsr   = ^lfsr_q[7:2];

  // Window restarts at full length each game and loses an eighth per hit, floored at MIN_UP
  always_comb begin
    up_len_d = up_len_q;
    if (!stop) begin
      if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
        up_len_d = UP_CYCLES;
      end else if (state_q == ST_UP && rise_q) begin
        up_len_d = (up_len_shrunk < MIN_UP) ? MIN_UP : up_len_shrunk;
      end
    end
  end

  // Up-window length register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_len_q <= UP_CYCLES;
    end else begin
      up_len_q <= up_len_d;
    end
  end

  assign up_len = up_len_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{lfsr_q[7:2], MIN_UP};
  assign up_len     = UP_CYCLES;
`endif

  // Round sequencing: gap, mole up, then hit or miss; stop overrides everything
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    round_d      = round_q;
    score_d      = score_q;
    sel_d        = sel_q;
    mole_up_d    = mole_up_q;
    game_over_d  = game_over_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      mole_up_d   = 1'b0;
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_GAP;
            score_d     = '0;
            round_d     = 8'd0;
            timer_d     = GAP_CYCLES - TMR_W'(1);
            game_over_d = 1'b0;
            mole_up_d   = 1'b0;
          end
        end
        ST_GAP: begin
          mole_up_d = 1'b0;
          if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
          end else begin
            state_d   = ST_UP;
            sel_d     = lfsr_q[1:0];
            timer_d   = up_len - TMR_W'(1);
            mole_up_d = 1'b1;
          end
        end
        ST_UP: begin
          if (rise_q || timer_q == '0) begin
            // A whack on the expiry cycle still counts as a hit
            if (rise_q) begin
              hit_pulse_d = 1'b1;
              if (score_q != SCORE_MAX) begin
                score_d = score_q + SCORE_ONE;
              end
            end else begin
              miss_pulse_d = 1'b1;
            end
            mole_up_d = 1'b0;
            round_d   = round_inc;
            if (round_inc == ROUNDS) begin
              state_d     = ST_DONE;
              game_over_d = 1'b1;
            end else begin
              state_d = ST_GAP;
              timer_d = GAP_CYCLES - TMR_W'(1);
            end
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      round_q      <= 8'd0;
      score_q      <= '0;
      sel_q        <= 2'd0;
      mole_up_q    <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      round_q      <= round_d;
      score_q      <= score_d;
      sel_q        <= sel_d;
      mole_up_q    <= mole_up_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      game_over_q  <= game_over_d;
    end
  end

  // Button edge detect, registered so only fresh presses reach the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      rise_q <= hit & ~hit_q;
    end
  end

  assign se1        = sel_q[1];
  assign se2        = sel_q[0];
  assign mole_up    = mole_up_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign score      = score_q;
  assign game_over  = game_over_q;

endmodule
